// File: rtl/cdc_4phase_mux_src.sv
// ---------------------------------------------------------------------------
// cdc_4phase_mux_src
//   Source half of a multi-channel 4-phase clock domain crossing. NumChannels
//   valid/ready channels are round-robin arbitrated onto one req/ack/data link.
//   The winning channel index travels with the payload so the destination
//   demux can route it.
//
// Ports
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   valid_i         per-channel valid
//   ready_o         per-channel ready (one-hot or zero)
//   data_i          per-channel payload, packed [NumChannels][DataWidth]
//   async_req_o     4-phase request (flop output)
//   async_ack_i     4-phase acknowledge from the destination domain
//   async_data_o    payload (flop output)
//   async_idx_o     channel index of the payload (flop output)
//   busy_o          high whenever a transfer is in flight
// ---------------------------------------------------------------------------

// Per-channel slice: flags whether the lane sits at or above the round-robin
// pointer, and decodes the shared grant into this lane's ready.
module cdc_4phase_mux_src_lane #(
  parameter int unsigned IdxWidth = 2,
  parameter int unsigned LaneIdx  = 0
) (
  input  logic                valid_i,
  input  logic [IdxWidth-1:0] ptr_i,
  input  logic                grant_en_i,
  input  logic [IdxWidth-1:0] grant_idx_i,
  output logic                hi_valid_o,
  output logic                ready_o
);
  localparam logic [IdxWidth-1:0] LaneId = IdxWidth'(LaneIdx);

  assign hi_valid_o = valid_i && (LaneId >= ptr_i);
  assign ready_o    = grant_en_i && (grant_idx_i == LaneId);
endmodule

module cdc_4phase_mux_src #(
  parameter int unsigned NumChannels = 4,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned SyncStages  = 2,
  parameter bit          Decoupled   = 1'b1,
  localparam int unsigned IdxWidth   = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NumChannels-1:0]                valid_i,
  output logic [NumChannels-1:0]                ready_o,
  input  logic [NumChannels-1:0][DataWidth-1:0] data_i,
  output logic                                  async_req_o,
  input  logic                                  async_ack_i,
  output logic [DataWidth-1:0]                  async_data_o,
  output logic [IdxWidth-1:0]                   async_idx_o,
  output logic                                  busy_o
);

  typedef enum logic [1:0] {
    IDLE              = 2'd0,
    WAIT_ACK_ASSERT   = 2'd1,
    WAIT_ACK_DEASSERT = 2'd2
  } state_e;

  state_e                 state_q;
  logic                   req_q;
  logic [DataWidth-1:0]   data_q;
  logic [IdxWidth-1:0]    idx_q;
  logic [IdxWidth-1:0]    ptr_q;
  logic [SyncStages-1:0]  ack_sync_q;
  logic                   ack_synced;

  logic [NumChannels-1:0] hi_valid;
  logic [IdxWidth-1:0]    winner;
  logic [IdxWidth-1:0]    ptr_nxt;
  logic                   accept;
  logic                   grant_en;
  logic [IdxWidth-1:0]    grant_idx;

  // ack synchroniser; the only reader of async_ack_i
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ack_sync_q <= '0;
    else         ack_sync_q <= {ack_sync_q[SyncStages-2:0], async_ack_i};
  end
  assign ack_synced = ack_sync_q[SyncStages-1];

  for (genvar g = 0; g < NumChannels; g++) begin : g_lane
    cdc_4phase_mux_src_lane #(
      .IdxWidth (IdxWidth),
      .LaneIdx  (g)
    ) u_lane (
      .valid_i     (valid_i[g]),
      .ptr_i       (ptr_q),
      .grant_en_i  (grant_en),
      .grant_idx_i (grant_idx),
      .hi_valid_o  (hi_valid[g]),
      .ready_o     (ready_o[g])
    );
  end

  // Round robin: lowest valid lane at/above ptr, else lowest valid lane
  // overall (wrap). Descending loops leave the lowest match in winner.
  always_comb begin
    winner = '0;
    for (int i = NumChannels - 1; i >= 0; i--)
      if (valid_i[i]) winner = IdxWidth'(i);
    for (int i = NumChannels - 1; i >= 0; i--)
      if (hi_valid[i]) winner = IdxWidth'(i);
  end

  assign ptr_nxt = (winner == IdxWidth'(NumChannels - 1)) ? '0 : winner + 1'b1;

  // ack_synced high in IDLE means the far side still holds a previous ack
  // (e.g. after a one-sided reset); hold off until it drops.
  assign accept = (state_q == IDLE) && (|valid_i) && !ack_synced;

  // ready is gated by reset so nothing is granted while the block is held.
  if (Decoupled) begin : g_dec
    assign grant_en  = rst_ni && accept;
    assign grant_idx = winner;
  end else begin : g_coupled
    assign grant_en  = rst_ni && (state_q == WAIT_ACK_DEASSERT) && !ack_synced;
    assign grant_idx = idx_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            data_q  <= data_i[winner];
            idx_q   <= winner;
            req_q   <= 1'b1;
            ptr_q   <= ptr_nxt;
            state_q <= WAIT_ACK_ASSERT;
          end
        end
        WAIT_ACK_ASSERT: begin
          if (ack_synced) begin
            req_q   <= 1'b0;
            state_q <= WAIT_ACK_DEASSERT;
          end
        end
        WAIT_ACK_DEASSERT: begin
          if (!ack_synced) state_q <= IDLE;
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign async_req_o  = req_q;
  assign async_data_o = data_q;
  assign async_idx_o  = idx_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_cdc_4phase_mux_src.sv
// Bench for cdc_4phase_mux_src: a decoupled and a coupled instance share the
// same stimulus and link; a transaction-level model predicts both each cycle.
module tb_cdc_4phase_mux_src;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int SS = 2;
  localparam int IW = 2;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic [N-1:0]         valid_i;
  logic [N-1:0][DW-1:0] data_i;
  logic                 async_ack_i;
  logic [N-1:0]         ready1, ready0;
  logic                 req1, req0, busy1, busy0;
  logic [DW-1:0]        data1, data0;
  logic [IW-1:0]        idx1, idx0;

  always #5 clk_i = ~clk_i;

  cdc_4phase_mux_src #(.NumChannels(N), .DataWidth(DW), .SyncStages(SS), .Decoupled(1'b1)) dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready1), .data_i(data_i),
    .async_req_o(req1), .async_ack_i(async_ack_i), .async_data_o(data1),
    .async_idx_o(idx1), .busy_o(busy1));

  cdc_4phase_mux_src #(.NumChannels(N), .DataWidth(DW), .SyncStages(SS), .Decoupled(1'b0)) dut0 (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready0), .data_i(data_i),
    .async_req_o(req0), .async_ack_i(async_ack_i), .async_data_o(data0),
    .async_idx_o(idx0), .busy_o(busy0));

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit            m_busy, m_acked, m_req;
  logic [DW-1:0] m_data;
  logic [IW-1:0] m_idx;
  int            m_ptr;
  bit            sync_q[$];

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_acked = 0; m_req = 0; m_data = '0; m_idx = '0; m_ptr = 0;
    sync_q.delete();
    repeat (SS) sync_q.push_back(1'b0);
  endtask

  // Compare mid-low-phase, then advance the model across the coming edge
  // (inputs are stable from here to the next negedge).
  initial begin
    model_reset();
    forever begin
      @(negedge clk_i);
      #2;
      begin
        bit           synced, acc;
        int           w;
        logic [N-1:0] er1, er0;
        if (!rst_ni) model_reset();
        synced = sync_q[0];
        acc    = rst_ni && !m_busy && (valid_i != '0) && !synced;
        w      = rr_pick(valid_i, m_ptr);
        er1 = '0; er0 = '0;
        if (acc) er1[w] = 1'b1;
        if (rst_ni && m_busy && m_acked && !synced) er0[m_idx] = 1'b1;
        check("ready_dec1", 64'(ready1), 64'(er1));
        check("ready_dec0", 64'(ready0), 64'(er0));
        check("link_dec1", {req1, busy1, idx1, data1}, {m_req, m_busy, m_idx, m_data});
        check("link_dec0", {req0, busy0, idx0, data0}, {m_req, m_busy, m_idx, m_data});
        if (rst_ni) begin
          if (acc) begin
            m_busy = 1; m_acked = 0; m_req = 1;
            m_data = data_i[w]; m_idx = IW'(w); m_ptr = (w + 1) % N;
          end else if (m_busy && !m_acked && synced) begin
            m_acked = 1; m_req = 0;
          end else if (m_busy && m_acked && !synced) begin
            m_busy = 0; m_acked = 0;
          end
          sync_q.push_back(async_ack_i);
          void'(sync_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus: producers + destination ----------------
  logic [DW-1:0] chq[N][$];
  logic [N-1:0]  done;
  int            grants[$];
  int            cnt1[N], cnt0[N];
  logic [N-1:0]  last_r1;
  logic [DW-1:0] last_data;
  int            last_idx;
  bit            req_prev;
  bit            rel_pending, ack_force, ack_force_val, rand_dly;
  int            dly, dcnt;

  task automatic cycle();
    @(negedge clk_i);
    if (rel_pending) begin rst_ni = 1'b1; rel_pending = 0; end
    for (int i = 0; i < N; i++)
      if (done[i] && chq[i].size() != 0) void'(chq[i].pop_front());
    for (int i = 0; i < N; i++) begin
      valid_i[i] = (chq[i].size() != 0);
      data_i[i]  = valid_i[i] ? chq[i][0] : DW'($urandom);
    end
    if (ack_force) async_ack_i = ack_force_val;
    else if (async_ack_i != req1) begin
      dcnt++;
      if (dcnt >= dly) begin
        async_ack_i = req1; dcnt = 0;
        if (rand_dly) dly = $urandom_range(0, 4);
      end
    end else dcnt = 0;
    #1;
    done = rst_ni ? ready0 : '0;
    for (int i = 0; i < N; i++) begin
      if (ready1[i]) begin cnt1[i]++; grants.push_back(i); last_r1 = ready1; end
      if (ready0[i]) cnt0[i]++;
    end
    if (req1 && !req_prev) begin last_data = data1; last_idx = int'(idx1); end
    req_prev = req1;
  endtask

  task automatic clear_stats();
    grants.delete();
    for (int i = 0; i < N; i++) begin cnt1[i] = 0; cnt0[i] = 0; end
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    for (int i = 0; i < N; i++) chq[i].delete();
    done = '0; req_prev = 0;
    repeat (3) cycle();
    rel_pending = 1;
    cycle();
  endtask

  task automatic run_grants(input int n);
    int k = 0;
    while (grants.size() < n && k < 300) begin cycle(); k++; end
    check("grant_timeout", 64'(grants.size() >= n), 64'd1);
  endtask

  task automatic wait_idle();
    int  k = 0;
    bit  empty;
    forever begin
      empty = 1;
      for (int i = 0; i < N; i++) if (chq[i].size() != 0) empty = 0;
      if ((empty && !busy1 && !busy0) || k >= 2000) break;
      cycle(); k++;
    end
    check("idle_timeout", 64'(k < 2000), 64'd1);
  endtask

  initial begin
    int exp_rr[6] = '{0, 1, 2, 3, 0, 1};
    int t_ack, t_fall, k, n;
    rst_ni = 1'b0; valid_i = '0; data_i = '0; async_ack_i = 1'b0;
    ack_force = 0; ack_force_val = 0; rand_dly = 0; dly = 3; dcnt = 0;
    done = '0; rel_pending = 0; last_r1 = '0; last_data = '0; last_idx = 0;
    clear_stats();

    // reset values
    do_reset();
    check("rst_outputs", {req1, busy1, idx1, data1, ready1, ready0},
          {1'b0, 1'b0, {IW{1'b0}}, {DW{1'b0}}, {N{1'b0}}, {N{1'b0}}});

    // single transfer on ch1
    clear_stats(); dly = 3;
    chq[1].push_back(32'hDEADBEEF);
    run_grants(1);
    check("t1_ready_onehot", 64'(last_r1), 64'(4'b0010));
    cycle();
    check("t1_link_idx", 64'(last_idx), 64'd1);
    check("t1_link_data", 64'(last_data), 64'hDEADBEEF);
    t_ack = -1; t_fall = -1; k = 0;
    while (t_fall < 0 && k < 50) begin
      cycle(); k++;
      if (t_ack < 0 && async_ack_i) t_ack = k;
      if (t_ack >= 0 && !req1) t_fall = k;
    end
    check("t1_req_fall_lat", 64'(t_fall - t_ack), 64'(SS + 1));
    wait_idle();
    check("t1_coupled_pulse", 64'(cnt0[1]), 64'd1);

    // continuous round robin, two rounds
    do_reset(); clear_stats(); dly = 1;
    for (int i = 0; i < N; i++) begin
      chq[i].push_back(32'hA0 + i);
      chq[i].push_back(32'hA0 + i);
    end
    run_grants(8);
    for (int i = 0; i < 6; i++) check("rr_order", 64'(grants[i]), 64'(exp_rr[i]));
    wait_idle();
    for (int i = 0; i < N; i++) check("rr_pulses", 64'(cnt1[i]), 64'd2);

    // fairness skip
    do_reset(); clear_stats(); dly = 2;
    chq[2].push_back(32'h2222);
    run_grants(1);
    check("skip_first", 64'(grants[0]), 64'd2);
    wait_idle(); clear_stats();
    chq[0].push_back(32'h0000_0C00);
    chq[3].push_back(32'h0000_0C03);
    run_grants(2);
    check("skip_ch3_first", 64'(grants[0]), 64'd3);
    check("skip_ch0_second", 64'(grants[1]), 64'd0);
    wait_idle();

    // coupled ready: exactly one pulse, nothing else accepted
    clear_stats(); dly = 3;
    chq[0].push_back(32'h55);
    wait_idle();
    check("dec0_pulse_ch0", 64'(cnt0[0]), 64'd1);
    check("dec0_others", 64'(cnt0[1] + cnt0[2] + cnt0[3]), 64'd0);
    check("dec0_data", 64'(last_data), 64'h55);

    // stale ack held through reset release
    ack_force = 1; ack_force_val = 1;
    do_reset(); clear_stats();
    repeat (3) cycle();
    chq[0].push_back(32'h77);
    n = 0;
    repeat (6) begin
      cycle();
      if (req1 || ready1 != '0) n++;
    end
    check("stale_hold", 64'(n), 64'd0);
    ack_force_val = 0;
    cycle();
    n = 0;
    while (grants.size() == 0 && n < 20) begin cycle(); n++; end
    check("stale_accept_lat", 64'(n), 64'(SS));
    ack_force = 0;
    wait_idle();

    // reset while waiting for ack
    clear_stats(); dly = 4;
    chq[1].push_back(32'hCAFE);
    k = 0;
    while (!req1 && k < 50) begin cycle(); k++; end
    cycle();
    #2 rst_ni = 1'b0;
    #1;
    check("midrst_outputs", {req1, busy1, ready1, ready0, req0, busy0},
          {1'b0, 1'b0, {N{1'b0}}, {N{1'b0}}, 1'b0, 1'b0});
    do_reset(); clear_stats();
    chq[3].push_back(32'h12345678);
    run_grants(1);
    cycle();
    check("midrst_idx", 64'(last_idx), 64'd3);
    check("midrst_data", 64'(last_data), 64'h12345678);
    wait_idle();

    // randomized traffic
    rand_dly = 1; clear_stats();
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        int ch = $urandom_range(0, N - 1);
        if (chq[ch].size() < 3) chq[ch].push_back(DW'($urandom));
      end
      cycle();
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
